// File: rtl/adder_share_ctrl.sv
// rtl/adder_share_ctrl.sv - shared approximate ripple adder for two requesters (optional ADDER_SHARE_ERR_MON_EN error monitor)
module adder_share_ctrl #(
    parameter int WIDTH       = 16,
    parameter int APPROX_BITS = 11
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
`ifdef ADDER_SHARE_ERR_MON_EN
    input  logic             err_clr,
    output logic [WIDTH:0]   err_max,
`endif
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH:0]   rsp_sum,
    output logic             rsp_id,
    output logic             busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic             last_was1_q;
    logic [WIDTH-1:0] op_a_q;
    logic [WIDTH-1:0] op_b_q;
    logic             op_id_q;
    logic [WIDTH:0]   sum_q;
    logic             id_q;
    logic             accept;
    logic             gnt0;
    logic             gnt1;
    logic             grant;
    logic [WIDTH:0]   approx_sum;

    // Round-robin arbitration: a grant is only possible while the operand slot is free
    always_comb begin
        accept = 1'b0;
        gnt0   = 1'b0;
        gnt1   = 1'b0;
        if (rst_n && (state_q == S_IDLE || (state_q == S_RESP && rsp_ready))) begin
            accept = 1'b1;
        end
        gnt0  = accept && req0_valid && (!req1_valid || last_was1_q);
        gnt1  = accept && req1_valid && (!req0_valid || !last_was1_q);
        grant = gnt0 || gnt1;
    end

    assign req0_ready = gnt0;
    assign req1_ready = gnt1;

    // Next-state logic for IDLE -> CALC -> RESP
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (grant) state_d = S_CALC;
            S_CALC: state_d = S_RESP;
            S_RESP: if (rsp_ready) state_d = grant ? S_CALC : S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Ripple adder: low bits pass b through and forward a as the carry, upper bits are exact
    always_comb begin
        logic c;
        approx_sum = '0;
        c          = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            if (i < APPROX_BITS) begin
                approx_sum[i] = op_b_q[i];
                c             = op_a_q[i];
            end else begin
                approx_sum[i] = op_a_q[i] ^ op_b_q[i] ^ c;
                c             = (op_a_q[i] & op_b_q[i]) | (c & (op_a_q[i] ^ op_b_q[i]));
            end
        end
        approx_sum[WIDTH] = c;
    end

    // State, operand capture at grant and result capture leaving CALC
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            last_was1_q <= 1'b1;
            op_a_q      <= '0;
            op_b_q      <= '0;
            op_id_q     <= 1'b0;
            sum_q       <= '0;
            id_q        <= 1'b0;
        end else begin
            state_q <= state_d;
            if (grant) begin
                op_a_q      <= gnt1 ? req1_a : req0_a;
                op_b_q      <= gnt1 ? req1_b : req0_b;
                op_id_q     <= gnt1;
                last_was1_q <= gnt1;
            end
            if (state_q == S_CALC) begin
                sum_q <= approx_sum;
                id_q  <= op_id_q;
            end
        end
    end

    assign rsp_valid = (state_q == S_RESP);
    assign rsp_sum   = sum_q;
    assign rsp_id    = id_q;
    assign busy      = (state_q != S_IDLE);

`ifdef ADDER_SHARE_ERR_MON_EN
    logic [WIDTH:0] exact_sum;
    logic [WIDTH:0] err_cur;
    logic [WIDTH:0] err_q;
    logic [WIDTH:0] err_max_q;

    // Exact reference and absolute error of the result being computed
    always_comb begin
        exact_sum = {1'b0, op_a_q} + {1'b0, op_b_q};
        err_cur   = (exact_sum >= approx_sum) ? (exact_sum - approx_sum) : (approx_sum - exact_sum);
    end

    // Track the worst error; a result counts once the consumer takes it
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_q     <= '0;
            err_max_q <= '0;
        end else begin
            if (state_q == S_CALC) err_q <= err_cur;
            if (err_clr) begin
                err_max_q <= '0;
            end else if (state_q == S_RESP && rsp_ready && err_q > err_max_q) begin
                err_max_q <= err_q;
            end
        end
    end

    assign err_max = err_max_q;
`endif

endmodule

// File: tb/tb_adder_share_ctrl.sv
// tb/tb_adder_share_ctrl.sv - directed self-checking bench for adder_share_ctrl
module tb_adder_share_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0_valid, req1_valid;
    logic        req0_ready, req1_ready;
    logic [15:0] req0_a, req0_b, req1_a, req1_b;
    logic        rsp_valid, rsp_ready, rsp_id, busy;
    logic [16:0] rsp_sum;
    logic        req0_ready_e, req1_ready_e, rsp_valid_e, rsp_id_e, busy_e;
    logic [16:0] rsp_sum_e;
    logic        err_clr;
`ifdef ADDER_SHARE_ERR_MON_EN
    logic [16:0] err_max, err_max_e;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    adder_share_ctrl #(.WIDTH(16), .APPROX_BITS(11)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
`ifdef ADDER_SHARE_ERR_MON_EN
        .err_clr(err_clr), .err_max(err_max),
`endif
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_sum(rsp_sum), .rsp_id(rsp_id),
        .busy(busy)
    );

    adder_share_ctrl #(.WIDTH(16), .APPROX_BITS(0)) u_exact (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready_e), .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready_e), .req1_a(req1_a), .req1_b(req1_b),
`ifdef ADDER_SHARE_ERR_MON_EN
        .err_clr(err_clr), .err_max(err_max_e),
`endif
        .rsp_valid(rsp_valid_e), .rsp_ready(rsp_ready), .rsp_sum(rsp_sum_e), .rsp_id(rsp_id_e),
        .busy(busy_e)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic apply_reset();
        rst_n      = 1'b0;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic run_one(input logic id, input logic [15:0] a, input logic [15:0] b,
                           input logic [16:0] exp_s, input logic [16:0] exp_e);
        int n;
        @(negedge clk);
        rsp_ready = 1'b1;
        if (id) begin
            req1_valid = 1'b1; req1_a = a; req1_b = b;
        end else begin
            req0_valid = 1'b1; req0_a = a; req0_b = b;
        end
        #1;
        n = 0;
        while (!(id ? req1_ready : req0_ready) && n < 20) begin
            @(negedge clk); #1;
            n++;
        end
        check("grant_ready", 32'(id ? req1_ready : req0_ready), 32'd1);
        @(negedge clk);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        #1;
        check("calc_busy", 32'(busy), 32'd1);
        check("calc_no_rsp", 32'(rsp_valid), 32'd0);
        @(negedge clk); #1;
        check("rsp_valid", 32'(rsp_valid), 32'd1);
        check("rsp_sum", 32'(rsp_sum), 32'(exp_s));
        check("rsp_id", 32'(rsp_id), 32'(id));
        check("exact_sum", 32'(rsp_sum_e), 32'(exp_e));
        @(negedge clk); #1;
        check("rsp_done", 32'(rsp_valid), 32'd0);
    endtask

    initial begin
        int gcyc[$];
        int gid[$];
        int rid[$];
        logic [16:0] rsum[$];

        rst_n = 1'b0; rsp_ready = 1'b0; err_clr = 1'b0;
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
        repeat (3) @(negedge clk);
        #1;
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_sum", 32'(rsp_sum), 32'd0);
        check("rst_id", 32'(rsp_id), 32'd0);
        check("rst_ready0", 32'(req0_ready), 32'd0);
        check("rst_ready1", 32'(req1_ready), 32'd0);
        rst_n = 1'b1;

        run_one(1'b0, 16'h0001, 16'h0001, 17'h00001, 17'h00002);
`ifdef ADDER_SHARE_ERR_MON_EN
        check("err_max_1", 32'(err_max), 32'd1);
`endif
        run_one(1'b0, 16'hFFFF, 16'hFFFF, 17'h1FFFF, 17'h1FFFE);
        run_one(1'b1, 16'h0400, 16'h0000, 17'h00800, 17'h00400);
        run_one(1'b0, 16'h8000, 16'h8000, 17'h10000, 17'h10000);
`ifdef ADDER_SHARE_ERR_MON_EN
        check("err_max_400", 32'(err_max), 32'h400);
        check("err_max_exact", 32'(err_max_e), 32'd0);
        @(negedge clk); err_clr = 1'b1;
        @(negedge clk); err_clr = 1'b0; #1;
        check("err_clr", 32'(err_max), 32'd0);
`endif

        // both requesters valid continuously
        apply_reset();
        rsp_ready = 1'b1;
        req0_a = 16'h0001; req0_b = 16'h0001;
        req1_a = 16'h0400; req1_b = 16'h0000;
        req0_valid = 1'b1; req1_valid = 1'b1;
        for (int c = 0; c < 8; c++) begin
            #1;
            if (req0_ready) begin gcyc.push_back(c); gid.push_back(0); end
            if (req1_ready) begin gcyc.push_back(c); gid.push_back(1); end
            if (rsp_valid) begin rid.push_back(int'(rsp_id)); rsum.push_back(rsp_sum); end
            @(negedge clk);
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        check("rr_grant_count", 32'(gid.size()), 32'd4);
        for (int i = 0; i < 4 && i < gid.size(); i++) begin
            check("rr_grant_id", 32'(gid[i]), 32'(i % 2));
            check("rr_grant_cycle", 32'(gcyc[i]), 32'(2 * i));
        end
        check("rr_rsp_count", 32'(rid.size()), 32'd3);
        for (int i = 0; i < 3 && i < rid.size(); i++) begin
            check("rr_rsp_id", 32'(rid[i]), 32'(i % 2));
            check("rr_rsp_sum", 32'(rsum[i]), (i % 2) ? 32'h800 : 32'h1);
        end

        // consumer stall while both requesters wait
        apply_reset();
        rsp_ready = 1'b0;
        req1_a = 16'hFFFF; req1_b = 16'hFFFF; req1_valid = 1'b1;
        #1;
        check("stall_grant1", 32'(req1_ready), 32'd1);
        @(negedge clk);
        req0_valid = 1'b1;
        #1;
        check("calc_ignore0", 32'(req0_ready), 32'd0);
        check("calc_ignore1", 32'(req1_ready), 32'd0);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk); #1;
            check("stall_valid", 32'(rsp_valid), 32'd1);
            check("stall_sum", 32'(rsp_sum), 32'h1FFFF);
            check("stall_id", 32'(rsp_id), 32'd1);
            check("stall_ready0", 32'(req0_ready), 32'd0);
            check("stall_ready1", 32'(req1_ready), 32'd0);
        end
        rsp_ready = 1'b1;
        #1;
        check("resp_regrant0", 32'(req0_ready), 32'd1);
        check("resp_regrant1", 32'(req1_ready), 32'd0);
        @(negedge clk);
        req0_valid = 1'b0; req1_valid = 1'b0;
        @(negedge clk); #1;
        check("post_stall_sum", 32'(rsp_sum), 32'h1);
        check("post_stall_id", 32'(rsp_id), 32'd0);

        // reset during CALC
        @(negedge clk);
        req1_valid = 1'b1;
        @(negedge clk);
        req1_valid = 1'b0;
        rst_n = 1'b0;
        @(negedge clk); #1;
        check("midrst_valid", 32'(rsp_valid), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        req0_valid = 1'b1; req1_valid = 1'b1;
        #1;
        check("postrst_gnt0", 32'(req0_ready), 32'd1);
        check("postrst_gnt1", 32'(req1_ready), 32'd0);
        @(negedge clk);
        req0_valid = 1'b0; req1_valid = 1'b0;
        @(negedge clk); #1;
        check("postrst_rsp_id", 32'(rsp_id), 32'd0);
        check("postrst_rsp_valid", 32'(rsp_valid), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/adder_share_ctrl.md
ADDER_SHARE_CTRL -- requirements
Module: adder_share_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 16, operand width.
REQ-002 SHALL have parameter APPROX_BITS, default 11, count of low approximate bit positions, legal range 0..WIDTH.
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have ports req0_valid / req1_valid  input  1  requester operand valid.
REQ-006 SHALL have ports req0_ready / req1_ready  output  1  operand accepted this cycle.
REQ-007 SHALL have ports req0_a, req0_b, req1_a, req1_b  input  WIDTH  operands.
REQ-008 SHALL have port rsp_valid  output  1  result available.
REQ-009 SHALL have port rsp_ready  input  1  consumer accepts result.
REQ-010 SHALL have port rsp_sum  output  WIDTH+1  sum including carry-out.
REQ-011 SHALL have port rsp_id  output  1  requester index of rsp_sum.
REQ-012 SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-013 SHALL share one WIDTH-bit ripple adder between two requesters with valid/ready handshakes; transfer occurs when valid and ready are both high.
REQ-014 SHALL compute bit i < APPROX_BITS as: sum_i = b_i, carry-out_i = a_i, carry-in ignored; carry into bit 0 is 0.
REQ-015 SHALL compute bits APPROX_BITS..WIDTH-1 as exact full adders; the final carry-out is rsp_sum[WIDTH].
REQ-016 SHALL run FSM IDLE -> CALC -> RESP: IDLE->CALC on a grant; CALC->RESP unconditionally; RESP->IDLE on rsp_ready with no new grant; RESP->CALC on rsp_ready with a new grant.
REQ-017 SHALL assert req*_ready only in IDLE, or in RESP in a cycle where rsp_ready is high; at most one req*_ready high per cycle.
REQ-018 SHALL register operands and requester index at grant, compute in CALC, register result entering RESP: grant in cycle N gives rsp_valid in cycle N+2.
REQ-019 SHALL hold rsp_valid, rsp_sum, rsp_id stable in RESP until rsp_ready is high.
REQ-020 SHALL arbitrate round-robin: with one valid, grant it; with both valid, grant the requester not granted last; after reset req0 has priority.
REQ-021 SHALL ignore request valids in CALC; no operand is dropped or duplicated.
REQ-022 SHALL treat APPROX_BITS=0 as a fully exact adder and APPROX_BITS=WIDTH as fully approximate, with rsp_sum[WIDTH] = a[WIDTH-1].

Reset
REQ-023 SHALL, while rst_n is low at a clock edge, enter IDLE, clear rsp_valid, rsp_sum, rsp_id, busy, req*_ready and set round-robin priority to req0.
REQ-024 SHALL discard any transaction in CALC or RESP when reset is applied mid-operation; no rsp_valid follows reset.

Configuration
REQ-025 SHALL, with macro ADDER_SHARE_ERR_MON_EN defined, add input err_clr (1) and output err_max (WIDTH+1): compute the exact sum in parallel and register the maximum |exact - approximate| over all completed results.
REQ-026 SHALL clear err_max on reset or err_clr; err_clr has priority over an update in the same cycle.
REQ-027 SHALL, without ADDER_SHARE_ERR_MON_EN, omit err_clr, err_max and exact-sum logic; all other behaviour identical.

Verification
REQ-028 SHALL cover: WIDTH=16, APPROX_BITS=11, req0 a=0x0001 b=0x0001 -> rsp_sum=0x00001, rsp_id=0, 2 cycles after grant; err_max=1 when monitor enabled.
REQ-029 SHALL cover: a=0xFFFF b=0xFFFF -> rsp_sum=0x1FFFF; a=0x0400 b=0x0000 -> rsp_sum=0x00800, err_max=0x400.
REQ-030 SHALL cover: both requesters valid continuously, rsp_ready=1 -> grants alternate 0,1,0,1 and one result per 2 cycles.
REQ-031 SHALL cover: rsp_ready held low 5 cycles in RESP -> rsp_sum/rsp_id stable, both req*_ready low throughout.
REQ-032 SHALL cover: rst_n low during CALC -> next cycle IDLE, rsp_valid=0, busy=0; first post-reset grant goes to req0.
REQ-033 SHALL cover: APPROX_BITS=0, a=0x8000 b=0x8000 -> rsp_sum=0x10000, err_max=0.
